// File: rtl/spi_slave_fifo_if.sv
// rtl/spi_slave_fifo_if.sv - SPI pins, TX/RX FIFO handshakes and status for spi_slave_fifo
interface spi_slave_fifo_if #(
    parameter int DATA_WDT = 8
);
    logic                cpol;
    logic                cpha;
    logic                ssel;
    logic                sclk;
    logic                mosi;
    logic                miso;
    logic                misoOe;
    logic [DATA_WDT-1:0] txData;
    logic                txValid;
    logic                txReady;
    logic [DATA_WDT-1:0] rxData;
    logic                rxValid;
    logic                rxReady;
    logic                txUnderrun;
    logic                rxOverrun;
    logic                busy;

    modport slave (
        input  cpol, cpha, ssel, sclk, mosi, txData, txValid, rxReady,
        output miso, misoOe, txReady, rxData, rxValid, txUnderrun, rxOverrun, busy
    );

    modport master (
        output cpol, cpha, ssel, sclk, mosi, txData, txValid, rxReady,
        input  miso, misoOe, txReady, rxData, rxValid, txUnderrun, rxOverrun, busy
    );
endinterface

// File: rtl/spi_slave_fifo.sv
// rtl/spi_slave_fifo.sv - oversampling SPI slave (all four modes) with FWFT TX and RX FIFOs
module spi_slave_fifo #(
    parameter int DATA_WDT    = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    spi_slave_fifo_if.slave  bus
);
    localparam int CW = $clog2(DATA_WDT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WDT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic                  cpol_q, cpha_q;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WDT-1:0]   tx_sh;
    logic [DATA_WDT-2:0]   rx_sh;
    logic                  busy_q, oe_q, underrun_q, overrun_q;

    logic [SYNC_STAGES-1:0] ssel_sync, sclk_sync, mosi_sync;
    logic ssel_s, sclk_s, mosi_s;
    logic ssel_d, sclk_d, mosi_q;
    logic lead_p, trail_p, sel_fall_p, sel_rise_p;

    assign ssel_s = ssel_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // ssel chain resets low so a slave select already low at reset release is not seen as a frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ssel_sync  <= '0;
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            ssel_d     <= 1'b0;
            sclk_d     <= 1'b0;
            mosi_q     <= 1'b0;
            lead_p     <= 1'b0;
            trail_p    <= 1'b0;
            sel_fall_p <= 1'b0;
            sel_rise_p <= 1'b0;
        end else begin
            ssel_sync  <= {ssel_sync[SYNC_STAGES-2:0], bus.ssel};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            ssel_d     <= ssel_s;
            sclk_d     <= sclk_s;
            mosi_q     <= mosi_s;
            lead_p     <= (sclk_s != sclk_d) && (sclk_d == cpol_q);
            trail_p    <= (sclk_s != sclk_d) && (sclk_s == cpol_q);
            sel_fall_p <= ssel_d && !ssel_s;
            sel_rise_p <= !ssel_d && ssel_s;
        end
    end

    logic [DATA_WDT-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]       tx_wptr, tx_rptr;
    logic [AW:0]         tx_count;
    logic [DATA_WDT-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]       rx_wptr, rx_rptr;
    logic [AW:0]         rx_count;

    logic tx_push, tx_pop, tx_empty, rx_push, rx_pop, rx_empty, rx_full;
    logic sample_ev, shift_ev, load_ev, rx_done;
    logic [DATA_WDT-1:0] tx_word, rx_word;

    assign tx_empty  = (tx_count == '0);
    assign rx_empty  = (rx_count == '0);
    assign rx_full   = (rx_count == FULL_CNT);
    assign tx_push   = bus.txValid && (tx_count != FULL_CNT);
    assign rx_pop    = !rx_empty && bus.rxReady;
    assign tx_word   = tx_empty ? '0 : tx_mem[tx_rptr];
    assign rx_word   = {rx_sh, mosi_q};

    assign sample_ev = (state == ACTIVE) && !sel_rise_p && (cpha_q ? trail_p : lead_p);
    assign shift_ev  = (state == ACTIVE) && !sel_rise_p && (cpha_q ? lead_p : trail_p);
    // a word boundary on the shift edge, or the frame start itself when cpha=0
    assign load_ev   = (shift_ev && (bit_cnt == '0)) ||
                       ((state == IDLE) && sel_fall_p && !bus.cpha);
    assign tx_pop    = load_ev && !tx_empty;
    assign rx_done   = sample_ev && (bit_cnt == LAST_BIT);
    assign rx_push   = rx_done && (!rx_full || rx_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            tx_count <= tx_count + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            rx_count <= rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= bus.txData;
        if (rx_push) rx_mem[rx_wptr] <= rx_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            bit_cnt    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            underrun_q <= load_ev && tx_empty;
            overrun_q  <= rx_done && !rx_push;
            case (state)
                IDLE: begin
                    if (sel_fall_p) begin
                        state   <= ACTIVE;
                        cpol_q  <= bus.cpol;
                        cpha_q  <= bus.cpha;
                        bit_cnt <= '0;
                        busy_q  <= 1'b1;
                        oe_q    <= 1'b1;
                        tx_sh   <= bus.cpha ? '0 : tx_word;
                    end
                end
                ACTIVE: begin
                    if (sel_rise_p) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        busy_q  <= 1'b0;
                        oe_q    <= 1'b0;
                        tx_sh   <= '0;
                    end else begin
                        if (shift_ev)
                            tx_sh <= (bit_cnt == '0) ? tx_word : {tx_sh[DATA_WDT-2:0], 1'b0};
                        if (sample_ev) begin
                            rx_sh   <= rx_word[DATA_WDT-2:0];
                            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miso       = tx_sh[DATA_WDT-1];
    assign bus.misoOe     = oe_q;
    assign bus.busy       = busy_q;
    assign bus.txUnderrun = underrun_q;
    assign bus.rxOverrun  = overrun_q;
    assign bus.txReady    = (tx_count != FULL_CNT);
    assign bus.rxValid    = !rx_empty;
    assign bus.rxData     = rx_empty ? '0 : rx_mem[rx_rptr];
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb/tb_spi_slave_fifo.sv - self-checking bench for spi_slave_fifo
module tb_spi_slave_fifo;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HALF  = SYNC + 6;
    localparam int LAT   = SYNC + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    spi_slave_fifo_if #(.DATA_WDT(W)) bus();

    spi_slave_fifo #(.DATA_WDT(W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int und_cnt = 0, ovr_cnt = 0, rv_rise = -1, busy_fall = -1;
    logic rv_prev = 1'b0, bs_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.rxValid && !rv_prev && rv_rise < 0) rv_rise = cyc;
        rv_prev = bus.rxValid;
        if (bs_prev && !bus.busy) busy_fall = cyc;
        bs_prev = bus.busy;
        if (bus.txUnderrun) und_cnt++;
        if (bus.rxOverrun) ovr_cnt++;
    end

    typedef struct {
        int         mode;
        int         nw;
        int         ntx;
        logic [7:0] tx [6];
        logic [7:0] mo [6];
        logic [7:0] mi [6];
        logic [7:0] rx [6];
        int         nrx;
        int         und;
        int         ovr;
    } vec_t;
    vec_t vecs [7];

    logic [7:0] txw [8], mosi_w [8], miso_w [8], exp_mi [8], exp_rx [8], got [8];
    int ngot, exp_nrx, exp_und, exp_ovr, w0_samp, ssel_rise_cyc;
    logic oe_seen;
    logic [7:0] txq [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] v);
        int t = 0;
        while (!bus.txReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("tx_push_ready", int'(bus.txReady), 1);
        bus.txData  = v;
        bus.txValid = 1'b1;
        @(negedge clk);
        bus.txValid = 1'b0;
    endtask

    task automatic drain();
        ngot = 0;
        bus.rxReady = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (bus.rxValid && ngot < 8) begin
                got[ngot] = bus.rxData;
                ngot++;
            end
            @(negedge clk);
        end
        bus.rxReady = 1'b0;
    endtask

    task automatic frame(input int mode, input int nbits);
        logic [1:0] m;
        logic cp;
        int w, k;
        m = 2'(mode);
        cp = m[1];
        bus.cpol = m[1];
        bus.cpha = m[0];
        bus.sclk = cp;
        wait_clk(HALF);
        bus.ssel = 1'b0;
        wait_clk(HALF);
        oe_seen = bus.busy & bus.misoOe;
        for (int b = 0; b < nbits; b++) begin
            w = b / W;
            k = W - 1 - (b % W);
            if (!m[0]) begin
                bus.mosi = mosi_w[w][k];
                wait_clk(HALF);
                bus.sclk = ~cp;
                miso_w[w][k] = bus.miso;
                if (w == 0 && k == 0) w0_samp = cyc;
                wait_clk(HALF);
                bus.sclk = cp;
            end else begin
                bus.sclk = ~cp;
                bus.mosi = mosi_w[w][k];
                wait_clk(HALF);
                bus.sclk = cp;
                miso_w[w][k] = bus.miso;
                if (w == 0 && k == 0) w0_samp = cyc;
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
        bus.ssel = 1'b1;
        ssel_rise_cyc = cyc;
        wait_clk(HALF);
    endtask

    task automatic run_check(input int mode, input int nw, input int ntx);
        int u0, o0;
        for (int i = 0; i < ntx; i++) push(txw[i]);
        u0 = und_cnt;
        o0 = ovr_cnt;
        rv_rise = -1;
        busy_fall = -1;
        frame(mode, nw * W);
        wait_clk(LAT + 4);
        for (int i = 0; i < nw; i++) chk("miso_word", int'(miso_w[i]), int'(exp_mi[i]));
        chk("tx_underrun_pulses", und_cnt - u0, exp_und);
        chk("rx_overrun_pulses", ovr_cnt - o0, exp_ovr);
        chk("busy_oe_in_frame", int'(oe_seen), 1);
        chk("busy_drop_latency", int'(busy_fall > ssel_rise_cyc && busy_fall - ssel_rise_cyc <= LAT), 1);
        chk("miso_oe_after_frame", int'(bus.misoOe), 0);
        if (exp_nrx > 0) chk("rx_valid_latency", rv_rise - w0_samp, LAT);
        drain();
        chk("rx_count", ngot, exp_nrx);
        for (int i = 0; i < exp_nrx; i++) chk("rx_word", int'(got[i]), int'(exp_rx[i]));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic saw;
        int u0, mode, nw, ntx, loads, und, nrx, ovr;
        logic [7:0] v;

        bus.ssel = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
        bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.txData = '0; bus.txValid = 1'b0; bus.rxReady = 1'b0;

        vecs[0] = '{0, 1, 2, '{8'hA5, 8'h00, 0, 0, 0, 0}, '{8'h3C, 0, 0, 0, 0, 0}, '{8'hA5, 0, 0, 0, 0, 0}, '{8'h3C, 0, 0, 0, 0, 0}, 1, 0, 0};
        vecs[1] = '{0, 3, 4, '{8'h01, 8'h80, 8'hFF, 8'h00, 0, 0}, '{8'h55, 8'hAA, 8'h0F, 0, 0, 0}, '{8'h01, 8'h80, 8'hFF, 0, 0, 0}, '{8'h55, 8'hAA, 8'h0F, 0, 0, 0}, 3, 0, 0};
        vecs[2] = '{1, 3, 3, '{8'h01, 8'h80, 8'hFF, 8'h00, 0, 0}, '{8'h55, 8'hAA, 8'h0F, 0, 0, 0}, '{8'h01, 8'h80, 8'hFF, 0, 0, 0}, '{8'h55, 8'hAA, 8'h0F, 0, 0, 0}, 3, 0, 0};
        vecs[3] = '{2, 3, 4, '{8'h01, 8'h80, 8'hFF, 8'h00, 0, 0}, '{8'h55, 8'hAA, 8'h0F, 0, 0, 0}, '{8'h01, 8'h80, 8'hFF, 0, 0, 0}, '{8'h55, 8'hAA, 8'h0F, 0, 0, 0}, 3, 0, 0};
        vecs[4] = '{3, 3, 3, '{8'h01, 8'h80, 8'hFF, 8'h00, 0, 0}, '{8'h55, 8'hAA, 8'h0F, 0, 0, 0}, '{8'h01, 8'h80, 8'hFF, 0, 0, 0}, '{8'h55, 8'hAA, 8'h0F, 0, 0, 0}, 3, 0, 0};
        vecs[5] = '{1, 2, 1, '{8'hC3, 0, 0, 0, 0, 0}, '{8'h12, 8'h34, 0, 0, 0, 0}, '{8'hC3, 8'h00, 0, 0, 0, 0}, '{8'h12, 8'h34, 0, 0, 0, 0}, 2, 1, 0};
        vecs[6] = '{3, 5, 0, '{0, 0, 0, 0, 0, 0}, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 0}, '{0, 0, 0, 0, 0, 0}, '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0}, 4, 5, 1};

        wait_clk(3);
        chk("reset_miso", int'(bus.miso), 0);
        chk("reset_miso_oe", int'(bus.misoOe), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_rx_valid", int'(bus.rxValid), 0);
        chk("reset_tx_ready", int'(bus.txReady), 1);
        chk("reset_rx_data", int'(bus.rxData), 0);
        chk("reset_pulses", int'({bus.txUnderrun, bus.rxOverrun}), 0);
        reset = 1'b0;
        wait_clk(SYNC + 4);
        chk("idle_busy", int'(bus.busy), 0);

        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 6; i++) begin
                txw[i] = vecs[r].tx[i];
                mosi_w[i] = vecs[r].mo[i];
                exp_mi[i] = vecs[r].mi[i];
                exp_rx[i] = vecs[r].rx[i];
            end
            exp_nrx = vecs[r].nrx;
            exp_und = vecs[r].und;
            exp_ovr = vecs[r].ovr;
            run_check(vecs[r].mode, vecs[r].nw, vecs[r].ntx);
        end

        // frame abandoned after five bits, then a clean frame
        push(8'h9A);
        u0 = und_cnt;
        rv_rise = -1;
        busy_fall = -1;
        mosi_w[0] = 8'hFF;
        frame(0, 5);
        wait_clk(LAT + 4);
        chk("partial_miso_bits", int'(miso_w[0][7:3]), 5'b10011);
        chk("partial_no_rx_push", int'(bus.rxValid), 0);
        chk("partial_no_underrun", und_cnt - u0, 0);
        chk("partial_busy_drop", int'(busy_fall > ssel_rise_cyc && busy_fall - ssel_rise_cyc <= LAT), 1);
        txw[0] = 8'h5E; txw[1] = 8'h00; mosi_w[0] = 8'hC7;
        exp_mi[0] = 8'h5E; exp_rx[0] = 8'hC7; exp_nrx = 1; exp_und = 0; exp_ovr = 0;
        run_check(0, 1, 2);

        // reset in the middle of a frame, with ssel still low at release
        push(8'h7E);
        push(8'h81);
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.sclk = 1'b0;
        wait_clk(HALF);
        bus.ssel = 1'b0;
        wait_clk(HALF);
        for (int b = 0; b < 3; b++) begin
            bus.mosi = 1'b1;
            wait_clk(HALF);
            bus.sclk = 1'b1;
            wait_clk(HALF);
            bus.sclk = 1'b0;
        end
        chk("busy_before_reset", int'(bus.busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", int'(bus.busy), 0);
        chk("async_reset_miso_oe", int'(bus.misoOe), 0);
        chk("async_reset_miso", int'(bus.miso), 0);
        chk("async_reset_rx_valid", int'(bus.rxValid), 0);
        chk("async_reset_tx_ready", int'(bus.txReady), 1);
        chk("async_reset_rx_data", int'(bus.rxData), 0);
        wait_clk(2);
        reset = 1'b0;
        saw = 1'b0;
        for (int b = 0; b < 2 * W; b++) begin
            bus.sclk = ~bus.sclk;
            repeat (HALF) begin
                @(negedge clk);
                saw |= bus.busy | bus.rxValid | bus.misoOe;
            end
        end
        chk("idle_while_ssel_low_after_reset", int'(saw), 0);
        bus.ssel = 1'b1;
        wait_clk(HALF);
        txw[0] = 8'h3C; txw[1] = 8'h00; mosi_w[0] = 8'hE1;
        exp_mi[0] = 8'h3C; exp_rx[0] = 8'hE1; exp_nrx = 1; exp_und = 0; exp_ovr = 0;
        run_check(0, 1, 2);

        // randomized frames against a queue-level model
        for (int it = 0; it < 8; it++) begin
            mode = $urandom_range(0, 3);
            nw   = $urandom_range(1, 5);
            ntx  = $urandom_range(0, DEPTH - txq.size());
            for (int i = 0; i < ntx; i++) begin
                txw[i] = 8'($urandom);
                txq.push_back(txw[i]);
            end
            for (int i = 0; i < nw; i++) mosi_w[i] = 8'($urandom);
            loads = nw + ((mode % 2 == 0) ? 1 : 0);
            und = 0;
            for (int l = 0; l < loads; l++) begin
                if (txq.size() > 0) v = txq.pop_front();
                else begin
                    v = 8'h00;
                    und++;
                end
                if (l < nw) exp_mi[l] = v;
            end
            nrx = 0;
            ovr = 0;
            for (int i = 0; i < nw; i++) begin
                if (nrx < DEPTH) begin
                    exp_rx[nrx] = mosi_w[i];
                    nrx++;
                end else ovr++;
            end
            exp_nrx = nrx; exp_und = und; exp_ovr = ovr;
            run_check(mode, nw, ntx);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
